// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding, default widths and cache geometry
package cache_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_CNT_WIDTH  = 16;

    // INNER_CACHE geometry: byte offset within a word, line index, tag
    localparam int TAG_WIDTH    = 10;
    localparam int INDEX_WIDTH  = 4;
    localparam int OFFSET_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_READ,
        FILL,
        MEM_WRITE,
        RESP
    } state_t;

    // bits needed for a wait counter that must hold values up to t
    function automatic int wait_width(input int t);
        return (t > 1) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter import cache_ctrl_pkg::*; #(
    parameter int WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // count one event per inc pulse, holding once the maximum is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: one-request-at-a-time sequencer between CPU, INNER_CACHE and backing memory
module cache_ctrl import cache_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_data_in,
    output logic                  cache_we,
    input  logic [DATA_WIDTH-1:0] cache_data_out,
    input  logic                  cache_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int WW = wait_width(TIMEOUT);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] cdin_q;
    logic [WW-1:0]         wait_q;
    logic                  ready_q;
    logic                  resp_q;
    logic                  err_q;
    logic                  cwe_q;
    logic                  mreq_q;
    logic                  mwe_q;
    logic                  hit_inc;
    logic                  miss_inc;
    logic                  expired;

    // every lookup, read or write, is classified exactly once
    assign hit_inc  = (state_q == LOOKUP) && cache_hit;
    assign miss_inc = (state_q == LOOKUP) && !cache_hit;

    // the current wait cycle is the last one allowed before giving up
    assign expired = (TIMEOUT != 0) && (int'(wait_q) == TIMEOUT - 1);

    // FSM with all CPU, cache and memory strobes registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cdin_q  <= '0;
            wait_q  <= '0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            cwe_q   <= 1'b0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
        end else begin
            cwe_q  <= 1'b0;
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        rdata_q <= '0;
                        cwe_q   <= cpu_we;
                        cdin_q  <= cpu_wdata;
                        ready_q <= 1'b0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        mreq_q  <= 1'b1;
                        mwe_q   <= 1'b1;
                        wait_q  <= '0;
                        state_q <= MEM_WRITE;
                    end else if (cache_hit) begin
                        rdata_q <= cache_data_out;
                        resp_q  <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        mreq_q  <= 1'b1;
                        mwe_q   <= 1'b0;
                        wait_q  <= '0;
                        state_q <= MEM_READ;
                    end
                end
                MEM_READ, MEM_WRITE: begin
                    if (mem_ack) begin
                        mreq_q <= 1'b0;
                        mwe_q  <= 1'b0;
                        if (state_q == MEM_READ) begin
                            rdata_q <= mem_rdata;
                            cdin_q  <= mem_rdata;
                            cwe_q   <= 1'b1;
                            state_q <= FILL;
                        end else begin
                            resp_q  <= 1'b1;
                            state_q <= RESP;
                        end
                    end else if (expired) begin
                        mreq_q  <= 1'b0;
                        mwe_q   <= 1'b0;
                        err_q   <= 1'b1;
                        resp_q  <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                FILL: begin
                    resp_q  <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    assign cpu_req_ready  = ready_q;
    assign cpu_resp_valid = resp_q;
    assign cpu_rdata      = rdata_q;
    assign cpu_err        = err_q;
    assign cache_addr     = addr_q;
    assign cache_data_in  = cdin_q;
    assign cache_we       = cwe_q;
    assign mem_req        = mreq_q;
    assign mem_we         = mwe_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Sequencing controller between a CPU-side request port, the direct-mapped INNER_CACHE array and a slower backing memory. It accepts one request at a time and performs the cache lookup. Read misses are refilled from memory (read-allocate). All writes are written through to memory and also update the cache (write-allocate). Hit and miss statistics counters and a memory-timeout error path are included.

Parameters:
DATA_WIDTH, 32, word width on all data buses
ADDR_WIDTH, 16, byte address width
TIMEOUT, 255, max cycles to wait for mem_ack before aborting; 0 disables the timeout
CNT_WIDTH, 16, width of the saturating hit/miss counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller can accept a request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_WIDTH  request address
cpu_wdata  in  DATA_WIDTH  write data
cpu_resp_valid  out  1  one-cycle response strobe
cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_resp_valid
cpu_err  out  1  memory timeout, valid with cpu_resp_valid
cache_addr  out  ADDR_WIDTH  to INNER_CACHE addr
cache_data_in  out  DATA_WIDTH  to INNER_CACHE data_in
cache_we  out  1  to INNER_CACHE write_enable
cache_data_out  in  DATA_WIDTH  from INNER_CACHE
cache_hit  in  1  from INNER_CACHE, combinational on cache_addr
mem_req  out  1  memory request, held until ack
mem_we  out  1  memory write
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  one-cycle completion strobe
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
hit_count  out  CNT_WIDTH  saturating lookup-hit counter
miss_count  out  CNT_WIDTH  saturating lookup-miss counter

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is asynchronous, active-high. On reset the state is IDLE and every output is 0, except cpu_req_ready=1. Counters and latched request registers clear to 0. A reset during any state aborts the transaction immediately: no response, and mem_req drops.
- States: IDLE, LOOKUP, MEM_READ, FILL, MEM_WRITE, RESP.
- IDLE: cpu_req_ready=1 only in IDLE. On valid&&ready, latch addr/we/wdata, then go to LOOKUP. CPU inputs are ignored outside IDLE.
- cache_addr: always driven from the latched address.
- LOOKUP (1 cycle): sample cache_hit.
  - Read hit: latch cache_data_out into cpu_rdata, hit_count+1, go to RESP.
  - Read miss: miss_count+1, go to MEM_READ.
  - Write: cache_we=1 and cache_data_in=latched wdata this cycle. Count a hit or miss per cache_hit. Go to MEM_WRITE.
- MEM_READ: mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ack: latch mem_rdata into cpu_rdata and go to FILL.
  - mem_ack in the first cycle of the state is legal.
- FILL (1 cycle): cache_we=1, cache_data_in=filled word, then go to RESP.
- MEM_WRITE: mem_req=1, mem_we=1, mem_wdata=latched wdata. On mem_ack, go to RESP. cpu_rdata=0 for writes.
- Timeout:
  - A wait counter clears on entry to MEM_READ or MEM_WRITE and increments each cycle without ack.
  - When the counter reaches TIMEOUT (and TIMEOUT≠0): drop mem_req, set cpu_err=1, go to RESP.
  - A read timeout does no FILL and drives cpu_rdata=0. A write timeout leaves the cache already updated.
- RESP (1 cycle): cpu_resp_valid=1 with cpu_rdata and cpu_err stable, then go to IDLE. cpu_err clears on leaving RESP.
- Latency, counted from the accept edge (cycle 0):
  - Read hit: cpu_resp_valid in cycle 2.
  - Read miss with ack after N wait cycles: cycle 4+N.
  - Write with ack after N wait cycles: cycle 3+N.
- Back-to-back: a new request is accepted in the cycle after RESP, giving a throughput of one request per 3 cycles on hits.
- Mismatched acks: mem_ack while mem_req=0 is ignored.
- Counters saturate at all-ones and do not wrap.
- mem_req and mem_we are registered outputs, glitch-free.

Decomposition:
- Package cache_ctrl_pkg holds:
  - the state_t enum;
  - the default widths;
  - the cache geometry constants TAG_WIDTH=10, INDEX_WIDTH=4, OFFSET_WIDTH=2, shared with INNER_CACHE.
- One sub-module, sat_counter (parameter WIDTH, inputs inc and rst), instantiated twice for hit_count and miss_count.
- The FSM, request latches and timeout counter stay in cache_ctrl.

Test Plan:
- After reset, read 0x0010 with memory returning 0xAABBCCDD after 3 wait cycles:
  - mem_req is seen with addr 0x0010.
  - cpu_resp_valid arrives at cycle 7 with rdata 0xAABBCCDD, err=0.
  - miss_count=1.
- Read 0x0010 again: cpu_resp_valid at cycle 2 with 0xAABBCCDD, hit_count=1, no mem_req.
- Write 0x11223344 to 0x0020 with ack immediate:
  - cache_we pulses in LOOKUP.
  - mem_we=1 with wdata 0x11223344.
  - Response at cycle 3.
  - A following read of 0x0020 hits with 0x11223344.
- Read 0x0410 (same index as 0x0010, different tag):
  - Miss, then refill with 0x55667788.
  - A subsequent read of 0x0010 misses again (eviction check).
- TIMEOUT=8 with mem_ack never asserted on a read of 0x0030:
  - mem_req drops after 8 cycles.
  - cpu_resp_valid with err=1 and rdata=0.
  - Re-reading 0x0030 still misses.
- Assert rst in MEM_READ: mem_req=0, cpu_req_ready=1 and counters=0 immediately after rst rises, with no cpu_resp_valid. Separately, force 2^CNT_WIDTH+ hits (CNT_WIDTH=4) and confirm hit_count holds at 0xF.
